// File: rtl/logic_gates_by_2x1_mux.sv
// Registered AND/OR/NAND/NOR/XOR unit whose datapath is built only from 2:1 muxes.
// Each bit's gates select on a[i] between constants, b[i] and an inverted b[i].

module mux2 (
  input  logic in0,
  input  logic in1,
  input  logic sel,
  output logic out
);
  assign out = sel ? in1 : in0;
endmodule

module logic_gates_by_2x1_mux #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5
);

  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] and_c;
  logic [WIDTH-1:0] or_c;
  logic [WIDTH-1:0] nand_c;
  logic [WIDTH-1:0] nor_c;
  logic [WIDTH-1:0] xor_c;

  // The inverted b is itself a mux, so NAND, NOR and XOR stay mux-only.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2 u_inv  (.in0(1'b1),  .in1(1'b0),  .sel(b[i]), .out(nb[i]));
    mux2 u_and  (.in0(1'b0),  .in1(b[i]),  .sel(a[i]), .out(and_c[i]));
    mux2 u_or   (.in0(b[i]),  .in1(1'b1),  .sel(a[i]), .out(or_c[i]));
    mux2 u_nand (.in0(1'b1),  .in1(nb[i]), .sel(a[i]), .out(nand_c[i]));
    mux2 u_nor  (.in0(nb[i]), .in1(1'b0),  .sel(a[i]), .out(nor_c[i]));
    mux2 u_xor  (.in0(b[i]),  .in1(nb[i]), .sel(a[i]), .out(xor_c[i]));
  end

  // Reset clears every output, including NAND/NOR which would otherwise idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1 <= '0;
      y2 <= '0;
      y3 <= '0;
      y4 <= '0;
      y5 <= '0;
    end else begin
      y1 <= and_c;
      y2 <= or_c;
      y3 <= nand_c;
      y4 <= nor_c;
      y5 <= xor_c;
    end
  end

endmodule

// File: tb/tb_logic_gates_by_2x1_mux.sv
// Directed bench for the mux-built gate unit: a 1-bit and a 4-bit instance
// share one clock and reset; all expected values are hand-computed constants.

module tb_logic_gates_by_2x1_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a, b;
  logic       y1, y2, y3, y4, y5;
  logic [3:0] a_w, b_w;
  logic [3:0] w1, w2, w3, w4, w5;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  logic_gates_by_2x1_mux #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5)
  );

  logic_gates_by_2x1_mux #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a_w), .b(b_w),
    .y1(w1), .y2(w2), .y3(w3), .y4(w4), .y5(w5)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
      $error("[TB] %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_narrow(input string tag, input logic [4:0] exp);
    check({tag, ".y1"}, {3'b0, y1}, {3'b0, exp[4]});
    check({tag, ".y2"}, {3'b0, y2}, {3'b0, exp[3]});
    check({tag, ".y3"}, {3'b0, y3}, {3'b0, exp[2]});
    check({tag, ".y4"}, {3'b0, y4}, {3'b0, exp[1]});
    check({tag, ".y5"}, {3'b0, y5}, {3'b0, exp[0]});
  endtask

  initial begin
    // Reset held with a=b=1 while the clock runs.
    rst_n = 1'b0;
    a = 1'b1; b = 1'b1;
    a_w = 4'b1111; b_w = 4'b1111;
    repeat (3) @(negedge clk);
    check_narrow("reset", 5'b00000);
    check("reset.w3", w3, 4'b0000);
    check("reset.w4", w4, 4'b0000);

    rst_n = 1'b1;
    @(negedge clk);
    check_narrow("release11", 5'b11000);

    // Exhaustive 1-bit sweep, order y1..y5 in the expected vector.
    a = 1'b0; b = 1'b0; @(negedge clk); check_narrow("ab00", 5'b00110);
    a = 1'b0; b = 1'b1; @(negedge clk); check_narrow("ab01", 5'b01101);
    a = 1'b1; b = 1'b0; @(negedge clk); check_narrow("ab10", 5'b01101);
    a = 1'b1; b = 1'b1; @(negedge clk); check_narrow("ab11", 5'b11000);

    // Latency: an input change between edges must not reach the outputs early.
    a = 1'b0; b = 1'b0; @(negedge clk);
    a = 1'b1; b = 1'b1;
    #2;
    check("lat_early.y1", {3'b0, y1}, 4'b0000);
    check("lat_early.y3", {3'b0, y3}, 4'b0001);
    @(posedge clk); #1;
    check_narrow("lat_after", 5'b11000);

    // Async reset pulse between edges with NAND/NOR outputs high.
    @(negedge clk);
    a = 1'b0; b = 1'b0;
    @(negedge clk);
    check_narrow("pre_pulse", 5'b00110);
    #2 rst_n = 1'b0;
    #1;
    check("pulse.y3", {3'b0, y3}, 4'b0000);
    check("pulse.y4", {3'b0, y4}, 4'b0000);
    #1 rst_n = 1'b1;
    #0.1;
    check("pulse_released.y3", {3'b0, y3}, 4'b0000);
    @(posedge clk); #1;
    check_narrow("post_pulse", 5'b00110);

    // 4-bit vectors.
    @(negedge clk);
    a_w = 4'b1100; b_w = 4'b1010;
    @(negedge clk);
    check("w_c_a.y1", w1, 4'b1000);
    check("w_c_a.y2", w2, 4'b1110);
    check("w_c_a.y3", w3, 4'b0111);
    check("w_c_a.y4", w4, 4'b0001);
    check("w_c_a.y5", w5, 4'b0110);

    a_w = 4'b0101; b_w = 4'b0011;
    @(negedge clk);
    check("w_5_3.y1", w1, 4'b0001);
    check("w_5_3.y2", w2, 4'b0111);
    check("w_5_3.y3", w3, 4'b1110);
    check("w_5_3.y4", w4, 4'b1000);
    check("w_5_3.y5", w5, 4'b0110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
